display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clocks per digit slot (1 ms at 50 MHz); SHALL be >= 4.
REQ-002 Parameter BLANK_CYC, default 500: anode-off cycles at the start of each slot (ghosting suppression); SHALL be < SCAN_DIV.
REQ-003 Parameter BLINK_DIV, default 25000000: clocks per half-period of the separator blink (0.5 s).
REQ-004 clk  input  1  system clock, 50 MHz; the block has a single clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 H1, H0, M1, M0, S1, S0  input  4 each  BCD digits hh:mm:ss from the stopwatch counter.
REQ-007 running  input  1  1 = stopwatch counting (separators blink), 0 = stopped (separators steady).
REQ-008 lz_blank  input  1  1 = blank leading hour zeros.
REQ-009 disp_en  input  1  0 = all anodes off; scanning continues.
REQ-010 an  output  6  digit anodes, active-low; an[0]=S0 ... an[5]=H1.
REQ-011 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 dp  output  1  decimal point, active-low.

Function
REQ-013 scan_cnt SHALL count 0..SCAN_DIV-1 and wrap; at its terminal count the slot index idx SHALL advance 0,1,2,3,4,5,0 (idx 0 = S0, idx 5 = H1).
REQ-014 Shadow registers SHALL capture all six input digits only on the edge where idx=5 and scan_cnt=SCAN_DIV-1 (frame boundary); between boundaries, input changes SHALL NOT affect the display (no tearing).
REQ-015 an, seg, dp SHALL be registered outputs reflecting the idx/scan_cnt/shadow state of the previous cycle (latency 1 clock).
REQ-016 an SHALL be 6'b111111 when scan_cnt < BLANK_CYC or disp_en=0; otherwise an SHALL be all ones except bit idx = 0.
REQ-017 seg decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 Shadow digit values 10..15 SHALL display a dash, seg=0111111.
REQ-019 With lz_blank=1: slot 5 SHALL show seg=1111111 when shadow H1=0; slot 4 SHALL show seg=1111111 when shadow H1=0 and H0=0; anodes SHALL still be scanned.
REQ-020 dp SHALL be 1 on slots 0, 1, 3, 5; on slots 2 and 4 (separators after M0, H0) dp SHALL be ~phase.
REQ-021 blink_cnt SHALL count 0..BLINK_DIV-1 while running=1, toggling phase at terminal count; while running=0, blink_cnt SHALL hold 0 and phase SHALL be 1 (separators steady on).
REQ-022 running rising edge SHALL restart the blink from blink_cnt=0, phase=1.
REQ-023 disp_en=0 SHALL force an=111111 only; seg, dp, counters, shadow load SHALL proceed unchanged.

Reset
REQ-024 On reset=1 at a clk edge: scan_cnt=0, idx=0, blink_cnt=0, phase=1, all shadow digits=0, an=6'b111111, seg=7'b1111111, dp=1.
REQ-025 Reset SHALL override all other activity, including a coincident frame-boundary load; reset asserted mid-frame SHALL restart at slot 0 with shadow cleared.
REQ-026 After reset release, the first frame SHALL display shadow values 0 (00:00:00, subject to lz_blank).

Verification (SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=16)
REQ-027 Reset 3 cycles -> an=111111, seg=1111111, dp=1; after release slot 0 shows an=111110, seg=1000000 from cycle 3 to 8 after release.
REQ-028 Inputs 23:59:48 held, wait one frame (48 cycles) -> slot0 seg=0000000, slot1 0011001, slot2 0010000, slot3 0010010, slot4 0110000, slot5 0100100; an one-hot-low order 0..5, 2 blank cycles per slot.
REQ-029 Change S0 from 8 to 9 mid-frame -> slot 0 remains 0000000 until the next frame boundary, then 0010000.
REQ-030 lz_blank=1, inputs 00:12:34 -> slots 5 and 4 seg=1111111 with anodes still driven; lz_blank=0 -> both 1000000.
REQ-031 running=1 -> dp on slots 2 and 4 toggles every 16 cycles starting low; running=0 -> dp=0 steady on slots 2, 4, dp=1 on others; disp_en=0 -> an=111111.
REQ-032 S1=4'hC -> slot 1 seg=0111111; reset asserted at idx=3 -> next slot idx 0 with seg=1000000.

Source files
------------

// File: rtl/display_scan.sv
// Six-digit multiplexed 7-segment scanner for an hh:mm:ss stopwatch display.
// Latency: an/seg/dp are registered, one clock behind the scan/shadow state.
// Backpressure: none; free-running scan, inputs captured once per frame.
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   H1..S0                - BCD digits hh:mm:ss (captured at frame boundary)
//   running               - 1 = separators blink, 0 = separators steady on
//   lz_blank              - blank leading hour zeros
//   disp_en               - 0 = anodes off (everything else keeps running)
//   an[5:0]               - active-low anodes, an[0]=S0 .. an[5]=H1
//   seg[6:0]              - active-low segments {g,f,e,d,c,b,a}
//   dp                    - active-low decimal point (separator)
module display_scan #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 500,
   parameter int BLINK_DIV = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] H1,
   input  logic [3:0] H0,
   input  logic [3:0] M1,
   input  logic [3:0] M0,
   input  logic [3:0] S1,
   input  logic [3:0] S0,
   input  logic       running,
   input  logic       lz_blank,
   input  logic       disp_en,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYC);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
   logic [2:0]        idx_q, idx_d;
   logic [5:0][3:0]   shd_q, shd_d;   // shd[0]=S0 .. shd[5]=H1
   logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
   logic              phase_q, phase_d;
   logic [5:0]        an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;

   logic [3:0]        digit;
   logic              lz_hide;

   // scan position and frame-boundary shadow capture
   always_comb begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      idx_d      = idx_q;
      shd_d      = shd_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         if (idx_q == 3'd5) begin
            idx_d = 3'd0;
            shd_d = {H1, H0, M1, M0, S1, S0};
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end
   end

   // Separator blink. Holding the counter at 0 / phase 1 while stopped means
   // a rising edge of running restarts the blink with no extra edge detector.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (!running) begin
         blink_cnt_d = '0;
         phase_d     = 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end else begin
         blink_cnt_d = blink_cnt_q + 1'b1;
      end
   end

   // output decode from the current slot
   always_comb begin
      case (idx_q)
         3'd0:    digit = shd_q[0];
         3'd1:    digit = shd_q[1];
         3'd2:    digit = shd_q[2];
         3'd3:    digit = shd_q[3];
         3'd4:    digit = shd_q[4];
         default: digit = shd_q[5];
      endcase

      lz_hide = lz_blank &&
                (((idx_q == 3'd5) && (shd_q[5] == 4'd0)) ||
                 ((idx_q == 3'd4) && (shd_q[5] == 4'd0) && (shd_q[4] == 4'd0)));

      case (digit)
         4'd0:    seg_d = 7'b1000000;
         4'd1:    seg_d = 7'b1111001;
         4'd2:    seg_d = 7'b0100100;
         4'd3:    seg_d = 7'b0110000;
         4'd4:    seg_d = 7'b0011001;
         4'd5:    seg_d = 7'b0010010;
         4'd6:    seg_d = 7'b0000010;
         4'd7:    seg_d = 7'b1111000;
         4'd8:    seg_d = 7'b0000000;
         4'd9:    seg_d = 7'b0010000;
         default: seg_d = 7'b0111111;   // non-BCD shows a dash
      endcase
      if (lz_hide) begin
         seg_d = 7'b1111111;
      end

      // anodes stay off for the first BLANK_CYC cycles of each slot
      if ((scan_cnt_q < BLANK_END) || !disp_en) begin
         an_d = 6'b111111;
      end else begin
         an_d = ~(6'b000001 << idx_q);
      end

      // separators sit after M0 (slot 2) and H0 (slot 4)
      if ((idx_q == 3'd2) || (idx_q == 3'd4)) begin
         dp_d = ~phase_q;
      end else begin
         dp_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt_q  <= '0;
         idx_q       <= 3'd0;
         shd_q       <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
         an_q        <= 6'b111111;
         seg_q       <= 7'b1111111;
         dp_q        <= 1'b1;
      end else begin
         scan_cnt_q  <= scan_cnt_d;
         idx_q       <= idx_d;
         shd_q       <= shd_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with a per-frame segment scoreboard.
// Expected slot segments are queued when digits are driven and checked
// cycle by cycle (an/seg/dp) over the frame that should display them.
module tb_display_scan;

   localparam int SD = 8;        // SCAN_DIV
   localparam int BC = 2;        // BLANK_CYC
   localparam int BD = 16;       // BLINK_DIV
   localparam int FR = SD * 6;   // cycles per frame

   typedef logic [5:0][6:0] frame_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] H1, H0, M1, M0, S1, S0;
   logic       running, lz_blank, disp_en;
   logic [5:0] an;
   logic [6:0] seg;
   logic       dp;

   int     total = 0;
   int     bad   = 0;
   int     k     = 0;    // edges since reset release
   int     ka    = 0;    // first edge that sampled running=1
   frame_t exp_q[$];

   display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
      .clk(clk), .reset(reset),
      .H1(H1), .H0(H0), .M1(M1), .M0(M0), .S1(S1), .S0(S0),
      .running(running), .lz_blank(lz_blank), .disp_en(disp_en),
      .an(an), .seg(seg), .dp(dp)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal;
   end

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      k++;
      #1;
   endtask

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input logic [3:0] h1, h0, m1, m0, s1, s0);
      frame_t f;
      f[0] = seg_of(s0);
      f[1] = seg_of(s1);
      f[2] = seg_of(m0);
      f[3] = seg_of(m1);
      f[4] = seg_of(h0);
      f[5] = seg_of(h1);
      if (lz_blank && h1 == 4'd0) f[5] = 7'b1111111;
      if (lz_blank && h1 == 4'd0 && h0 == 4'd0) f[4] = 7'b1111111;
      exp_q.push_back(f);
   endtask

   task automatic push_cur();
      push_exp(H1, H0, M1, M0, S1, S0);
   endtask

   task automatic drive(input logic [3:0] h1, h0, m1, m0, s1, s0);
      H1 = h1; H0 = h0; M1 = m1; M0 = m0; S1 = s1; S0 = s0;
      push_cur();
   endtask

   // advance to a frame boundary strictly after the current moment
   task automatic wait_frame();
      do tick(); while (k % FR != 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_an"},  {1'b0, an},     7'h3F);
      check({tag, "_seg"}, seg,            7'h7F);
      check({tag, "_dp"},  {6'd0, dp},     7'd1);
   endtask

   // must be entered with k % FR == 0; checks the next displayed frame
   task automatic check_frame(input string tag);
      frame_t     f;
      int         p, slot, cnt;
      logic [5:0] e_an;
      logic       e_dp;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s_queue: got empty scoreboard expected one frame", tag);
         return;
      end
      f = exp_q.pop_front();
      for (int c = 0; c < FR; c++) begin
         tick();
         p    = k - 1;
         slot = (p / SD) % 6;
         cnt  = p % SD;
         e_an = (cnt < BC || !disp_en) ? 6'h3F : ~(6'b000001 << slot);
         if (slot == 2 || slot == 4)
            e_dp = running ? (((k - ka) / BD) % 2 == 1) : 1'b0;
         else
            e_dp = 1'b1;
         check($sformatf("%s_an_k%0d", tag, k),  {1'b0, an}, {1'b0, e_an});
         check($sformatf("%s_seg_k%0d", tag, k), seg,        f[slot]);
         check($sformatf("%s_dp_k%0d", tag, k),  {6'd0, dp}, {6'd0, e_dp});
      end
   endtask

   initial begin
      reset = 1'b1;
      H1 = 4'd0; H0 = 4'd0; M1 = 4'd0; M0 = 4'd0; S1 = 4'd0; S0 = 4'd0;
      running = 1'b0; lz_blank = 1'b0; disp_en = 1'b1;

      repeat (3) tick();
      check_reset_outputs("reset");

      // first frame after release shows cleared shadow 00:00:00
      reset = 1'b0;
      k = 0;
      push_exp(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
      check_frame("boot");

      drive(4'd2, 4'd3, 4'd5, 4'd9, 4'd4, 4'd8);
      wait_frame();
      check_frame("t235948");

      // S0 change right after a boundary must not tear the frame
      push_cur();
      S0 = 4'd9;
      check_frame("tear_hold");
      push_cur();
      check_frame("tear_new");

      lz_blank = 1'b1;
      drive(4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4);
      wait_frame();
      check_frame("lz_on");
      lz_blank = 1'b0;
      push_cur();
      check_frame("lz_off");

      lz_blank = 1'b1;
      drive(4'd0, 4'd5, 4'd1, 4'd2, 4'd3, 4'd4);
      wait_frame();
      check_frame("lz_h1only");
      lz_blank = 1'b0;

      running = 1'b1;
      ka = k + 1;
      push_cur();
      wait_frame();
      check_frame("blink_a");
      push_cur();
      check_frame("blink_b");

      running = 1'b0;
      push_cur();
      wait_frame();
      check_frame("steady");

      disp_en = 1'b0;
      push_cur();
      wait_frame();
      check_frame("disp_off");
      disp_en = 1'b1;

      drive(4'd2, 4'd3, 4'd5, 4'd9, 4'hC, 4'd8);
      wait_frame();
      check_frame("dash");

      // reset in the middle of slot 3
      do tick(); while (((k - 1) / SD) % 6 != 3);
      reset = 1'b1;
      tick();
      check_reset_outputs("rst_mid");
      tick();
      reset = 1'b0;
      k = 0;
      exp_q.delete();
      push_exp(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
      check_frame("post_rst");
      push_cur();
      check_frame("post_rst_load");

      // reset on the frame-boundary edge must beat the shadow load
      repeat (FR - 1) tick();
      reset = 1'b1;
      tick();
      check_reset_outputs("rst_bound");
      reset = 1'b0;
      k = 0;
      push_exp(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
      check_frame("bound_clear");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
